// File: rtl/pcpi_result_nibble_tx.sv
// Nibble-serial transmitter for a 32-bit PCPI result word, LS nibble first, 4-phase valid/ack handshake.
// Optional ACK_TIMEOUT_EN aborts a word whose far end stops answering for TIMEOUT_CYCLES cycles.
module pcpi_result_nibble_tx #(
  parameter int NIBBLES        = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  input  logic [4*NIBBLES-1:0]   load_data,
  output logic                   load_ready,
  output logic [3:0]             nib_data,
  output logic                   nib_valid,
  input  logic                   nib_ack,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  // Handshake: nib_valid rises with a new nibble (SEND); the far end raises nib_ack once it has
  // taken it; nib_valid then drops (RELEASE) and the next nibble waits until nib_ack is low again.
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t               state;
  logic [4*NIBBLES-1:0] shift;
  logic [4*NIBBLES-1:0] shift_next;
  logic [CW-1:0]        count;
  logic                 advance;
  logic                 timeout;

  assign shift_next = shift >> 4;
  assign advance    = (state == SEND && nib_ack) || (state == RELEASE && !nib_ack);
  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

`ifdef ACK_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_cnt;

  // A phase that completes on the very cycle the budget runs out still counts as completed.
  assign timeout = busy && !advance && (wait_cnt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!busy || advance || timeout) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      count     <= '0;
      nib_valid <= 1'b0;
      nib_data  <= 4'h0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= timeout;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shift     <= load_data;
            count     <= '0;
            nib_data  <= load_data[3:0];
            nib_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (timeout) begin
            nib_valid <= 1'b0;
            state     <= IDLE;
          end else if (nib_ack) begin
            nib_valid <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (timeout) begin
            state <= IDLE;
          end else if (!nib_ack) begin
            if (count == LAST) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              shift     <= shift_next;
              count     <= count + CW'(1);
              nib_data  <= shift_next[3:0];
              nib_valid <= 1'b1;
              state     <= SEND;
            end
          end
        end
        default: begin
          nib_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
